// File: rtl/mil_spi_cmd_router_pkg.sv
// Shared ServiceProtocol definitions for the SPI <-> MIL-STD-1553 command router:
// command codes, router FSM states, mux key widths and the address decode helper.
package mil_spi_cmd_router_pkg;

    // ServiceProtocol transfer command codes carried in the SPI header
    typedef enum logic [3:0] {
        TCC_UNKNOWN      = 4'h0,
        TCC_SEND_DATA    = 4'h1,
        TCC_RECEIVE_DATA = 4'h2,
        TCC_RECEIVE_STS  = 4'h3,
        TCC_RESET        = 4'h4
    } tcc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV_DATA,
        ST_RECV_STS,
        ST_RST
    } router_state_t;

    // External mux key widths: PushMux takes a channel, BusMux takes {channel, status}
    localparam int PUSH_KEY_W = 3;
    localparam int POP_KEY_W  = PUSH_KEY_W + 1;

    // Internal channel index width, at least one bit even for a single channel
    function automatic int ch_idx_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Raw channel offset of a block address; the caller range-checks it
    function automatic logic [7:0] addr_to_ch(input logic [7:0] addr, input logic [7:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/mil_spi_cmd_router_txn_ctrl.sv
// mil_spi_txn_ctrl: per-direction ring-buffer transaction pulse generator.
// Latches the channel on open so commit/rollback always target the buffer
// that was actually opened; all pulses are registered, one-hot and exclusive.
module mil_spi_txn_ctrl
    import mil_spi_cmd_router_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                open_req,
    input  logic                commit_req,
    input  logic                rollback_req,
    input  logic [CH_W-1:0]     ch,
    output logic [CHANNELS-1:0] open_o,
    output logic [CHANNELS-1:0] commit_o,
    output logic [CHANNELS-1:0] rollback_o
);

    logic                active_q, active_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic                do_open, do_commit, do_rollback;
    logic [CHANNELS-1:0] open_q, open_d;
    logic [CHANNELS-1:0] commit_q, commit_d;
    logic [CHANNELS-1:0] rollback_q, rollback_d;

    // Transaction bookkeeping: rollback wins over commit, open only when nothing is pending
    always_comb begin
        active_d    = active_q;
        sel_d       = sel_q;
        do_open     = 1'b0;
        do_commit   = 1'b0;
        do_rollback = 1'b0;
        if (active_q) begin
            if (rollback_req) begin
                do_rollback = 1'b1;
                active_d    = 1'b0;
            end else if (commit_req) begin
                do_commit = 1'b1;
                active_d  = 1'b0;
            end
        end else if (open_req) begin
            do_open  = 1'b1;
            active_d = 1'b1;
            sel_d    = ch;
        end
    end

    // One-hot channel decode of each pulse
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(gi);
        assign open_d[gi]     = do_open && (ch == IDX);
        assign commit_d[gi]   = do_commit && (sel_q == IDX);
        assign rollback_d[gi] = do_rollback && (sel_q == IDX);
    end

    // Pulse and bookkeeping registers
    always_ff @(posedge clk) begin
        if (!nRst) begin
            active_q   <= 1'b0;
            sel_q      <= '0;
            open_q     <= '0;
            commit_q   <= '0;
            rollback_q <= '0;
        end else begin
            active_q   <= active_d;
            sel_q      <= sel_d;
            open_q     <= open_d;
            commit_q   <= commit_d;
            rollback_q <= rollback_d;
        end
    end

    assign open_o     = open_q;
    assign commit_o   = commit_q;
    assign rollback_o = rollback_q;

endmodule

// File: rtl/mil_spi_cmd_router.sv
// mil_spi_cmd_router: N-channel command router between LinkSpi and the MIL channels.
// Registers the decoded SPI header, drives PushMux/BusMux keys, the reply header,
// per-channel ring-buffer open/commit/rollback and a stretched reset request.
// Optional: define MIL_SPI_ROUTER_TIMEOUT_EN to abort transactions that see no
// frame_end within TIMEOUT cycles (treated as a failed frame).
module mil_spi_cmd_router
    import mil_spi_cmd_router_pkg::*;
#(
    parameter int          CHANNELS    = 2,
    parameter logic [7:0]  ADDR_BASE   = 8'hAB,
    parameter int          SIZE_W      = 16,
    parameter int          RESET_PULSE = 16,
    parameter int          TIMEOUT     = 65535
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  logic                       hdr_valid,
    input  logic [7:0]                 in_addr,
    input  logic [3:0]                 in_cmd,
    input  logic                       frame_end,
    input  logic                       frame_err,
    input  logic [CHANNELS*SIZE_W-1:0] mem_used_ms,
    input  logic [CHANNELS*SIZE_W-1:0] mem_used_sm,
    input  logic [SIZE_W-1:0]          status_size,
    output logic [CHANNELS-1:0]        ms_open,
    output logic [CHANNELS-1:0]        ms_commit,
    output logic [CHANNELS-1:0]        ms_rollback,
    output logic [CHANNELS-1:0]        sm_open,
    output logic [CHANNELS-1:0]        sm_commit,
    output logic [CHANNELS-1:0]        sm_rollback,
    output logic [PUSH_KEY_W-1:0]      push_ch,
    output logic [POP_KEY_W-1:0]       pop_key,
    output logic                       out_en,
    output logic [7:0]                 out_addr,
    output logic [3:0]                 out_cmd,
    output logic [SIZE_W-1:0]          out_size,
    output logic [CHANNELS-1:0]        mil_tx_en,
    output logic                       nResetRequest
);

    localparam int CH_W  = ch_idx_w(CHANNELS);
    localparam int RST_W = $clog2(RESET_PULSE + 1);

    router_state_t             state_q, state_d;
    logic [PUSH_KEY_W-1:0]     push_ch_q, push_ch_d;
    logic [POP_KEY_W-1:0]      pop_key_q, pop_key_d;
    logic                      out_en_q, out_en_d;
    logic [7:0]                out_addr_q, out_addr_d;
    tcc_t                      out_cmd_q, out_cmd_d;
    logic [SIZE_W-1:0]         out_size_q, out_size_d;
    logic [CHANNELS-1:0]       tx_en_q, tx_en_d;
    logic                      nrr_q, nrr_d;
    logic [RST_W-1:0]          rst_cnt_q, rst_cnt_d;

    logic [7:0]                hdr_off;
    logic                      hdr_hit;
    logic [CH_W-1:0]           hdr_ch;
    logic                      frame_done, frame_bad;
    logic                      ms_open_req, ms_commit_req, ms_rb_req;
    logic                      sm_open_req, sm_commit_req, sm_rb_req;
    logic [SIZE_W-1:0]         ms_used [CHANNELS];
    logic [SIZE_W-1:0]         sm_used [CHANNELS];

`ifdef MIL_SPI_ROUTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
`endif

    // Split the flat fill-level buses into per-channel words
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_used
        assign ms_used[gi] = mem_used_ms[gi*SIZE_W +: SIZE_W];
        assign sm_used[gi] = mem_used_sm[gi*SIZE_W +: SIZE_W];
    end

    // Header address decode; a header coinciding with frame_end is dropped
    assign hdr_off = addr_to_ch(in_addr, ADDR_BASE);
    assign hdr_ch  = hdr_off[CH_W-1:0];
    assign hdr_hit = hdr_valid && !frame_end && (32'(hdr_off) < CHANNELS);

    // Router FSM next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        push_ch_d     = push_ch_q;
        pop_key_d     = pop_key_q;
        out_en_d      = out_en_q;
        out_addr_d    = out_addr_q;
        out_cmd_d     = out_cmd_q;
        out_size_d    = out_size_q;
        nrr_d         = nrr_q;
        rst_cnt_d     = rst_cnt_q;
        ms_open_req   = 1'b0;
        ms_commit_req = 1'b0;
        ms_rb_req     = 1'b0;
        sm_open_req   = 1'b0;
        sm_commit_req = 1'b0;
        sm_rb_req     = 1'b0;
        frame_done    = frame_end;
        frame_bad     = frame_err;
`ifdef MIL_SPI_ROUTER_TIMEOUT_EN
        // A stalled frame is closed as if LinkSpi had reported an error
        to_cnt_d = to_cnt_q + 1'b1;
        if (state_q == ST_IDLE || state_q == ST_RST) begin
            to_cnt_d = '0;
        end else if (!frame_end && to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            frame_done = 1'b1;
            frame_bad  = 1'b1;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (hdr_hit) begin
                    case (in_cmd)
                        TCC_SEND_DATA: begin
                            push_ch_d   = PUSH_KEY_W'(hdr_ch);
                            sm_open_req = 1'b1;
                            state_d     = ST_SEND;
                        end
                        TCC_RECEIVE_DATA: begin
                            out_size_d  = ms_used[hdr_ch];
                            pop_key_d   = {PUSH_KEY_W'(hdr_ch), 1'b0};
                            out_addr_d  = in_addr;
                            out_cmd_d   = TCC_RECEIVE_DATA;
                            out_en_d    = 1'b1;
                            ms_open_req = 1'b1;
                            state_d     = ST_RECV_DATA;
                        end
                        TCC_RECEIVE_STS: begin
                            out_size_d = status_size;
                            pop_key_d  = {PUSH_KEY_W'(hdr_ch), 1'b1};
                            out_addr_d = in_addr;
                            out_cmd_d  = TCC_RECEIVE_STS;
                            out_en_d   = 1'b1;
                            state_d    = ST_RECV_STS;
                        end
                        TCC_RESET: begin
                            nrr_d     = 1'b0;
                            rst_cnt_d = RST_W'(RESET_PULSE - 1);
                            state_d   = ST_RST;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SEND: begin
                if (frame_done) begin
                    sm_rb_req     = frame_bad;
                    sm_commit_req = !frame_bad;
                    out_en_d      = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            ST_RECV_DATA: begin
                if (frame_done) begin
                    ms_rb_req     = frame_bad;
                    ms_commit_req = !frame_bad;
                    out_en_d      = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            ST_RECV_STS: begin
                if (frame_done) begin
                    out_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RST: begin
                if (rst_cnt_q == '0) begin
                    nrr_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // BusPusher enables use the next state so an open SEND buffer is gated from its first cycle
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_tx
        localparam logic [PUSH_KEY_W-1:0] IDX = PUSH_KEY_W'(gi);
        assign tx_en_d[gi] = (sm_used[gi] != '0) && !(state_d == ST_SEND && push_ch_d == IDX);
    end

    // Router state and output registers
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q    <= ST_IDLE;
            push_ch_q  <= '0;
            pop_key_q  <= '0;
            out_en_q   <= 1'b0;
            out_addr_q <= '0;
            out_cmd_q  <= TCC_UNKNOWN;
            out_size_q <= '0;
            tx_en_q    <= '0;
            nrr_q      <= 1'b1;
            rst_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            push_ch_q  <= push_ch_d;
            pop_key_q  <= pop_key_d;
            out_en_q   <= out_en_d;
            out_addr_q <= out_addr_d;
            out_cmd_q  <= out_cmd_d;
            out_size_q <= out_size_d;
            tx_en_q    <= tx_en_d;
            nrr_q      <= nrr_d;
            rst_cnt_q  <= rst_cnt_d;
        end
    end

`ifdef MIL_SPI_ROUTER_TIMEOUT_EN
    // Frame watchdog counter
    always_ff @(posedge clk) begin
        if (!nRst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    mil_spi_txn_ctrl #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_ms_txn (
        .clk          (clk),
        .nRst         (nRst),
        .open_req     (ms_open_req),
        .commit_req   (ms_commit_req),
        .rollback_req (ms_rb_req),
        .ch           (hdr_ch),
        .open_o       (ms_open),
        .commit_o     (ms_commit),
        .rollback_o   (ms_rollback)
    );

    mil_spi_txn_ctrl #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_sm_txn (
        .clk          (clk),
        .nRst         (nRst),
        .open_req     (sm_open_req),
        .commit_req   (sm_commit_req),
        .rollback_req (sm_rb_req),
        .ch           (hdr_ch),
        .open_o       (sm_open),
        .commit_o     (sm_commit),
        .rollback_o   (sm_rollback)
    );

    assign push_ch       = push_ch_q;
    assign pop_key       = pop_key_q;
    assign out_en        = out_en_q;
    assign out_addr      = out_addr_q;
    assign out_cmd       = out_cmd_q;
    assign out_size      = out_size_q;
    assign mil_tx_en     = tx_en_q;
    assign nResetRequest = nrr_q;

endmodule

// File: tb/tb_mil_spi_cmd_router.sv
// Directed testbench for mil_spi_cmd_router (CHANNELS=2, RESET_PULSE=16, TIMEOUT=100).
module tb_mil_spi_cmd_router;
    import mil_spi_cmd_router_pkg::*;

    logic        clk = 1'b0;
    logic        nRst;
    logic        hdr_valid;
    logic [7:0]  in_addr;
    logic [3:0]  in_cmd;
    logic        frame_end;
    logic        frame_err;
    logic [31:0] mem_used_ms;
    logic [31:0] mem_used_sm;
    logic [15:0] status_size;
    logic [1:0]  ms_open, ms_commit, ms_rollback;
    logic [1:0]  sm_open, sm_commit, sm_rollback;
    logic [2:0]  push_ch;
    logic [3:0]  pop_key;
    logic        out_en;
    logic [7:0]  out_addr;
    logic [3:0]  out_cmd;
    logic [15:0] out_size;
    logic [1:0]  mil_tx_en;
    logic        nResetRequest;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] ctl_seen;

    always #5 clk = ~clk;

    mil_spi_cmd_router #(
        .CHANNELS    (2),
        .ADDR_BASE   (8'hAB),
        .SIZE_W      (16),
        .RESET_PULSE (16),
        .TIMEOUT     (100)
    ) dut (
        .clk           (clk),
        .nRst          (nRst),
        .hdr_valid     (hdr_valid),
        .in_addr       (in_addr),
        .in_cmd        (in_cmd),
        .frame_end     (frame_end),
        .frame_err     (frame_err),
        .mem_used_ms   (mem_used_ms),
        .mem_used_sm   (mem_used_sm),
        .status_size   (status_size),
        .ms_open       (ms_open),
        .ms_commit     (ms_commit),
        .ms_rollback   (ms_rollback),
        .sm_open       (sm_open),
        .sm_commit     (sm_commit),
        .sm_rollback   (sm_rollback),
        .push_ch       (push_ch),
        .pop_key       (pop_key),
        .out_en        (out_en),
        .out_addr      (out_addr),
        .out_cmd       (out_cmd),
        .out_size      (out_size),
        .mil_tx_en     (mil_tx_en),
        .nResetRequest (nResetRequest)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
        ctl_seen = ctl_seen | {ms_open, ms_commit, ms_rollback, sm_open, sm_commit, sm_rollback};
    endtask

    task automatic hdr(input logic [7:0] a, input tcc_t c);
        hdr_valid = 1'b1;
        in_addr   = a;
        in_cmd    = c;
    endtask

    task automatic idle_in();
        hdr_valid = 1'b0;
        frame_end = 1'b0;
        frame_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        int hit;
        nRst        = 1'b0;
        hdr_valid   = 1'b0;
        in_addr     = 8'h00;
        in_cmd      = 4'h0;
        frame_end   = 1'b0;
        frame_err   = 1'b0;
        mem_used_ms = {16'd9, 16'd7};
        mem_used_sm = {16'd5, 16'd0};
        status_size = 16'd3;
        ctl_seen    = '0;

        // Reset state
        cyc(); cyc();
        check("rst_out_en", 32'(out_en), 32'd0);
        check("rst_out_cmd", 32'(out_cmd), 32'(TCC_UNKNOWN));
        check("rst_nrr", 32'(nResetRequest), 32'd1);
        check("rst_tx_en", 32'(mil_tx_en), 32'd0);
        check("rst_ctl", 32'(ctl_seen), 32'd0);
        nRst = 1'b1;
        cyc();
        check("idle_tx_en", 32'(mil_tx_en), 32'b10);
        $display("txn reset release done");

        // SEND_DATA to channel 1, with a stray header mid-transaction
        hdr(8'hAC, TCC_SEND_DATA);
        cyc();
        idle_in();
        check("send_open", 32'(sm_open), 32'b10);
        check("send_push_ch", 32'(push_ch), 32'd1);
        check("send_tx_gated", 32'(mil_tx_en), 32'b00);
        cyc();
        check("send_open_1cyc", 32'(sm_open), 32'b00);
        hdr(8'hAB, TCC_RECEIVE_DATA);
        cyc();
        idle_in();
        check("busy_hdr_out_en", 32'(out_en), 32'd0);
        check("busy_hdr_ms_open", 32'(ms_open), 32'd0);
        check("busy_hdr_push_ch", 32'(push_ch), 32'd1);
        check("send_tx_still_gated", 32'(mil_tx_en), 32'b00);
        frame_end = 1'b1;
        cyc();
        idle_in();
        check("send_commit", 32'(sm_commit), 32'b10);
        check("send_no_rb", 32'(sm_rollback), 32'b00);
        check("send_tx_released", 32'(mil_tx_en), 32'b10);
        cyc();
        check("send_commit_1cyc", 32'(sm_commit), 32'b00);
        $display("txn send ch1 committed");

        // Out-of-range address and header coinciding with frame_end are dropped
        hdr(8'hAD, TCC_SEND_DATA);
        cyc();
        idle_in();
        check("bad_addr_open", 32'(sm_open), 32'b00);
        hdr(8'hAB, TCC_RECEIVE_STS);
        frame_end = 1'b1;
        cyc();
        idle_in();
        check("hdr_with_fe_out_en", 32'(out_en), 32'd0);
        $display("txn dropped headers done");

        // RECEIVE_DATA channel 0, failed frame
        hdr(8'hAB, TCC_RECEIVE_DATA);
        cyc();
        idle_in();
        mem_used_ms = {16'd9, 16'd12};
        check("rd_out_size", 32'(out_size), 32'd7);
        check("rd_out_addr", 32'(out_addr), 32'hAB);
        check("rd_pop_key", 32'(pop_key), 32'd0);
        check("rd_out_cmd", 32'(out_cmd), 32'(TCC_RECEIVE_DATA));
        check("rd_out_en", 32'(out_en), 32'd1);
        check("rd_open", 32'(ms_open), 32'b01);
        cyc();
        check("rd_size_held", 32'(out_size), 32'd7);
        frame_end = 1'b1;
        frame_err = 1'b1;
        cyc();
        idle_in();
        check("rd_rollback", 32'(ms_rollback), 32'b01);
        check("rd_no_commit", 32'(ms_commit), 32'b00);
        check("rd_out_en_off", 32'(out_en), 32'd0);
        $display("txn recv_data ch0 rolled back");

        // RECEIVE_STS channel 1: no buffer activity at all
        cyc();
        ctl_seen = '0;
        hdr(8'hAC, TCC_RECEIVE_STS);
        cyc();
        idle_in();
        check("sts_pop_key", 32'(pop_key), 32'b0011);
        check("sts_out_size", 32'(out_size), 32'd3);
        check("sts_out_en", 32'(out_en), 32'd1);
        cyc(); cyc();
        frame_end = 1'b1;
        cyc();
        idle_in();
        cyc();
        check("sts_out_en_off", 32'(out_en), 32'd0);
        check("sts_no_ctl", 32'(ctl_seen), 32'd0);
        $display("txn recv_sts ch1 done");

        // RESET: 16-cycle low pulse, second RESET ignored
        hdr(8'hAB, TCC_RESET);
        cyc();
        idle_in();
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (nResetRequest == 1'b0) low_cnt++;
            if (i == 5) hdr(8'hAB, TCC_RESET);
            if (i == 7) frame_end = 1'b1;
            cyc();
            idle_in();
        end
        check("rst_pulse_len", 32'(low_cnt), 32'd16);
        check("rst_pulse_end", 32'(nResetRequest), 32'd1);
        check("rst_no_ctl", 32'(ctl_seen), 32'd0);
        $display("txn reset request done");

        // Back in IDLE: a new SEND on channel 0 is accepted
        hdr(8'hAB, TCC_SEND_DATA);
        cyc();
        idle_in();
        check("post_rst_open", 32'(sm_open), 32'b01);
        check("post_rst_push_ch", 32'(push_ch), 32'd0);
        hit = 0;
        for (int k = 1; k <= 150; k++) begin
            cyc();
            if (sm_rollback != 2'b00 && hit == 0) hit = k;
        end
`ifdef MIL_SPI_ROUTER_TIMEOUT_EN
        check("timeout_cycle", 32'(hit), 32'd100);
        check("timeout_one_hot", 32'(ctl_seen[1:0]), 32'b01);
        hdr(8'hAC, TCC_SEND_DATA);
        cyc();
        idle_in();
        check("timeout_idle", 32'(sm_open), 32'b10);
        frame_end = 1'b1;
        cyc();
        idle_in();
        check("timeout_next_commit", 32'(sm_commit), 32'b10);
`else
        check("no_timeout", 32'(hit), 32'd0);
        frame_end = 1'b1;
        cyc();
        idle_in();
        check("late_commit", 32'(sm_commit), 32'b01);
`endif
        $display("txn long send ch0 done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mil_spi_cmd_router.md
Name: mil_spi_cmd_router

Overview:
- N-channel command router between the SPI link layer and N MIL-STD-1553 channels. Supersedes the fixed two-channel combinational decode.
- Registers each decoded SPI header and selects push/pop mux paths.
- Drives per-channel ring-buffer transactions (open/commit/rollback) so that a failed SPI frame never corrupts or loses buffered words.
- Generates the reply header and a stretched reset request.

Parameters:
- CHANNELS, 2: number of MIL channels, 1..8; channel i answers address ADDR_BASE+i.
- ADDR_BASE, 8'hAB: SPI address of channel 0.
- SIZE_W, 16: width of memUsed and reply size fields.
- RESET_PULSE, 16: cycles nResetRequest is held low; must be >=1.
- TIMEOUT, 65535: cycles without frame_end before an open transaction is aborted; must be >=1.

Ports:
- clk  in  1  clock
- nRst  in  1  reset
- hdr_valid  in  1  one-cycle strobe: in_addr/in_cmd valid (from LinkSpi)
- in_addr  in  8  received block address
- in_cmd  in  4  received command code (ServiceProtocol TCC_*)
- frame_end  in  1  one-cycle strobe: SPI frame closed
- frame_err  in  1  qualifies frame_end: CRC/length error
- mem_used_ms  in  CHANNELS*SIZE_W  fill of mil->spi buffers
- mem_used_sm  in  CHANNELS*SIZE_W  fill of spi->mil buffers
- status_size  in  SIZE_W  status block length in words
- ms_open, ms_commit, ms_rollback  out  CHANNELS each  mil->spi buffer control
- sm_open, sm_commit, sm_rollback  out  CHANNELS each  spi->mil buffer control
- push_ch  out  3  PushMux key: destination channel
- pop_key  out  4  BusMux key: {channel, 1=status/0=data}
- out_en  out  1  LinkSpi reply enable
- out_addr  out  8  reply address
- out_cmd  out  4  reply command code
- out_size  out  SIZE_W  reply data size
- mil_tx_en  out  CHANNELS  BusPusher enables
- nResetRequest  out  1  active-low reset request

Behaviour:
- Reset (synchronous, nRst low on a clk edge): state IDLE. All buffer controls 0; out_en 0; out_addr 0; out_cmd TCC_UNKNOWN; out_size 0; push_ch 0; pop_key 0; mil_tx_en 0; nResetRequest 1; counters 0.
- Address match: ch = in_addr-ADDR_BASE, accepted only if in range 0..CHANNELS-1. Unmatched address or unknown command: stay IDLE, no outputs change.
- FSM states: IDLE, SEND, RECV_DATA, RECV_STS, RST.
- Decode latency: hdr_valid in cycle T gives registered outputs in T+1.
- IDLE + hdr_valid:
  - TCC_SEND_DATA: push_ch<=ch; sm_open[ch] one-cycle pulse; go to SEND.
  - TCC_RECEIVE_DATA: out_size<=mem_used_ms[ch], snapshotted at the header and not re-sampled; pop_key<={ch,0}; out_addr<=in_addr; out_cmd<=in_cmd; out_en<=1; ms_open[ch] pulse; go to RECV_DATA.
  - TCC_RECEIVE_STS: same header fields, but out_size<=status_size and pop_key<={ch,1}; no buffer open; go to RECV_STS.
  - TCC_RESET: nResetRequest low for exactly RESET_PULSE cycles, then 1; go to RST, then back to IDLE.
- SEND/RECV_DATA + frame_end:
  - frame_err=0: commit pulse on the open buffer.
  - frame_err=1: rollback pulse on the open buffer.
  - Then go to IDLE with out_en<=0.
- RECV_STS + frame_end: go to IDLE, out_en<=0; no buffer pulses.
- hdr_valid while not IDLE: ignored; the active transaction is preserved.
- Simultaneous hdr_valid and frame_end: frame_end is processed. The header is dropped, because LinkSpi cannot legally issue both.
- Each open/commit/rollback is exactly one cycle wide, one-hot across channels, and never asserted together.
- mil_tx_en[i] (registered) = mem_used_sm[i]!=0 AND NOT (state==SEND AND push_ch==i). Uncommitted data is never transmitted.
- In RST, frame_end is ignored and no buffer pulses occur. A further TCC_RESET during RST is ignored.
- Reset mid-transaction: no rollback is issued. The ring buffers are reset by the same nRst.

Optional Feature:
- Macro MIL_SPI_ROUTER_TIMEOUT_EN.
- Defined: a counter runs in SEND/RECV_DATA/RECV_STS and clears on state entry. When it reaches TIMEOUT, the router acts as frame_end with frame_err=1: rollback if a buffer is open, out_en<=0, go to IDLE.
- Undefined: no counter; the router waits for frame_end indefinitely.

Decomposition:
- ServiceProtocol package gains: TCC_* codes as a 4-bit enum; typedef router_state_t; function addr_to_ch(). PushMux/BusMux2 key widths are derived from CHANNELS.
- One sub-module: mil_spi_txn_ctrl, the per-direction open/commit/rollback pulse generator with a one-hot channel select, instantiated twice (ms, sm).

Test Plan:
- CHANNELS=2: SEND_DATA to 8'hAC, then frame_end with err=0 -> sm_open[1] pulses at T+1; push_ch=1; mil_tx_en[1]=0 until sm_commit[1] pulses; then mil_tx_en[1]=1 if mem_used_sm[1]=5.
- RECEIVE_DATA to 8'hAB with mem_used_ms[0]=7, then frame_end with err=1 -> out_size=7, out_addr=8'hAB, pop_key=0, ms_open[0] pulse, then ms_rollback[0] pulse and out_en=0.
- RECEIVE_STS to 8'hAC with status_size=3 -> pop_key=4'b0011, out_size=3; no open/commit/rollback at any time.
- RESET to 8'hAB, RESET_PULSE=16 -> nResetRequest low for exactly 16 cycles; a second RESET during the pulse has no effect.
- Address 8'hAD with CHANNELS=2, plus hdr_valid during an active SEND -> no output change, and the active SEND later commits normally.
- TIMEOUT_EN, TIMEOUT=100: SEND with no frame_end -> sm_rollback pulse on cycle 100 after entry, state IDLE.
